// File: rtl/stw_pkg.sv
// Shared types and constants for the self-test-window sequencer: state encoding,
// the fixed multiply-add vector table and the Galois LFSR step.
package stw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_CHECK,
        ST_NEXT,
        ST_DONE
    } stw_state_e;

    typedef struct packed {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] add;
    } stw_vec_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Negative entries are stored as their 16-bit two's complement patterns.
    function automatic stw_vec_t fixedVec(input logic [2:0] idx);
        stw_vec_t v;
        case (idx)
            3'd0:    v = '{op1: 16'd3,    op2: 16'd5,    add: 16'd7};
            3'd1:    v = '{op1: 16'hFFFF, op2: 16'hFFFF, add: 16'h0000};
            3'd2:    v = '{op1: 16'h7FFF, op2: 16'h0002, add: 16'h0000};
            3'd3:    v = '{op1: 16'h0000, op2: 16'h1234, add: 16'h5678};
            3'd4:    v = '{op1: 16'h00FF, op2: 16'h0100, add: 16'h0001};
            3'd5:    v = '{op1: 16'hFFFE, op2: 16'h0003, add: 16'hFFFC};
            3'd6:    v = '{op1: 16'h8000, op2: 16'hFFFF, add: 16'h0000};
            default: v = '{op1: 16'h0001, op2: 16'h0001, add: 16'hFFFF};
        endcase
        return v;
    endfunction

    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/stw_vec_gen.sv
// Test-vector source with registered operands and expected multiply-add result.
// Define STW_LFSR_VECTORS_EN to draw vectors from the LFSR instead of the fixed table.
module stw_vec_gen #(
    parameter int          WORD_SIZE = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 loadEn_i,
    input  logic                 stepEn_i,
    input  logic [7:0]           vecIdx_i,
    output logic [WORD_SIZE-1:0] op1_o,
    output logic [WORD_SIZE-1:0] op2_o,
    output logic [WORD_SIZE-1:0] add_o,
    output logic [WORD_SIZE-1:0] expected_o
);
    import stw_pkg::*;

    logic [WORD_SIZE-1:0] op1_d, op2_d, add_d;
    logic [WORD_SIZE-1:0] op1_q, op2_q, add_q, exp_q;

    function automatic logic [WORD_SIZE-1:0] fitWord(input logic [15:0] v);
        logic [31:0] w;
        w = {16'h0000, v};
        return w[WORD_SIZE-1:0];
    endfunction

    // Full-width signed product plus sign-extended addend, wrapped to one word.
    function automatic logic [WORD_SIZE-1:0] macWord(input logic [WORD_SIZE-1:0] a,
                                                      input logic [WORD_SIZE-1:0] b,
                                                      input logic [WORD_SIZE-1:0] c);
        logic [2*WORD_SIZE-1:0] full;
        full = {{WORD_SIZE{a[WORD_SIZE-1]}}, a} * {{WORD_SIZE{b[WORD_SIZE-1]}}, b}
             + {{WORD_SIZE{c[WORD_SIZE-1]}}, c};
        return full[WORD_SIZE-1:0];
    endfunction

`ifdef STW_LFSR_VECTORS_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        unusedIdx;

    assign unusedIdx = ^vecIdx_i;

    // A load without a step presents the current LFSR value as the sweep's first vector.
    always_comb begin
        lfsr_d = stepEn_i ? lfsrStep(lfsr_q) : lfsr_q;
        op1_d  = fitWord(lfsr_d);
        op2_d  = fitWord({lfsr_d[7:0], lfsr_d[15:8]});
        add_d  = fitWord(~lfsr_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    stw_vec_t tblVec;
    logic     unusedCfg;

    assign unusedCfg = ^{LFSR_SEED, stepEn_i, vecIdx_i[7:3]};

    always_comb begin
        tblVec = fixedVec(vecIdx_i[2:0]);
        op1_d  = fitWord(tblVec.op1);
        op2_d  = fitWord(tblVec.op2);
        add_d  = fitWord(tblVec.add);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op1_q <= '0;
            op2_q <= '0;
            add_q <= '0;
            exp_q <= '0;
        end else if (loadEn_i) begin
            op1_q <= op1_d;
            op2_q <= op2_d;
            add_q <= add_d;
            exp_q <= macWord(op1_d, op2_d, add_d);
        end
    end

    assign op1_o      = op1_q;
    assign op2_o      = op2_q;
    assign add_o      = add_q;
    assign expected_o = exp_q;

endmodule

// File: rtl/stw_controller.sv
// Self-test-window sequencer: drives a row of PEs with multiply-add vectors and builds a fault map.
// Define STW_LFSR_VECTORS_EN for LFSR-generated vectors; the default uses the fixed table.
module stw_controller #(
    parameter int          WORD_SIZE = 16,
    parameter int          NUM_PE    = 4,
    parameter int          NUM_VEC   = 8,
    parameter int          TIMEOUT   = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 test_req,
    output logic                 test_busy,
    output logic                 test_done,
    output logic [NUM_PE-1:0]    fault_map,
    output logic                 STW_test_load_en,
    output logic [WORD_SIZE-1:0] STW_mult_op1,
    output logic [WORD_SIZE-1:0] STW_mult_op2,
    output logic [WORD_SIZE-1:0] STW_add_op,
    output logic [WORD_SIZE-1:0] STW_expected,
    output logic                 STW_start,
    input  logic [NUM_PE-1:0]    STW_complete,
    input  logic [NUM_PE-1:0]    STW_result_out
);
    import stw_pkg::*;

    localparam int             TW         = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]     LAST_IDX   = 8'(NUM_VEC - 1);

    stw_state_e        state_q;
    logic              busy_q, done_q, load_q, start_q;
    logic [NUM_PE-1:0] fault_q;
    logic [TW-1:0]     timer_q;
    logic [7:0]        vecIdx_q;

    logic              lastVec;
    logic              genLoad, genStep;
    logic [7:0]        genIdx;

    assign lastVec = (vecIdx_q == LAST_IDX);

    // The generator registers a new vector on sweep start and when advancing in NEXT.
    always_comb begin
        genLoad = 1'b0;
        genStep = 1'b0;
        genIdx  = 8'd0;
        case (state_q)
            ST_IDLE: genLoad = test_req;
            ST_NEXT: begin
                genStep = 1'b1;
                genLoad = !lastVec;
                genIdx  = vecIdx_q + 8'd1;
            end
            default: ;
        endcase
    end

    // Outputs are registered alongside the state so each strobe lines up with its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            load_q   <= 1'b0;
            start_q  <= 1'b0;
            fault_q  <= '0;
            timer_q  <= '0;
            vecIdx_q <= '0;
        end else begin
            load_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (test_req) begin
                        state_q  <= ST_LOAD;
                        busy_q   <= 1'b1;
                        load_q   <= 1'b1;
                        fault_q  <= '0;
                        vecIdx_q <= '0;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_START;
                    start_q <= 1'b1;
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                    timer_q <= '0;
                end
                ST_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    if ((timer_q != '0) && ((&STW_complete) || (timer_q == TIMER_LAST))) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    fault_q <= fault_q | ~(STW_complete & STW_result_out);
                    state_q <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (lastVec) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        vecIdx_q <= vecIdx_q + 8'd1;
                        state_q  <= ST_LOAD;
                        load_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    stw_vec_gen #(
        .WORD_SIZE (WORD_SIZE),
        .LFSR_SEED (LFSR_SEED)
    ) u_vec_gen (
        .clk        (clk),
        .rst        (rst),
        .loadEn_i   (genLoad),
        .stepEn_i   (genStep),
        .vecIdx_i   (genIdx),
        .op1_o      (STW_mult_op1),
        .op2_o      (STW_mult_op2),
        .add_o      (STW_add_op),
        .expected_o (STW_expected)
    );

    assign test_busy        = busy_q;
    assign test_done        = done_q;
    assign fault_map        = fault_q;
    assign STW_test_load_en = load_q;
    assign STW_start        = start_q;

endmodule

// File: tb/tb_stw_controller.sv
// Self-checking bench for stw_controller: a cycle schedule derived from the PE behaviour
// predicts every output each cycle; directed sweeps pin latency and fault-map literals.
module tb_stw_controller;

    localparam int          NPE  = 4;
    localparam int          NV   = 8;
    localparam int          TO   = 64;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk;
    logic        rst;
    logic        test_req;
    logic        test_busy, test_done;
    logic [3:0]  fault_map;
    logic        STW_test_load_en, STW_start;
    logic [15:0] STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;
    logic [3:0]  STW_complete, STW_result_out;

    stw_controller #(
        .WORD_SIZE (16),
        .NUM_PE    (NPE),
        .NUM_VEC   (NV),
        .TIMEOUT   (TO),
        .LFSR_SEED (SEED)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .test_req         (test_req),
        .test_busy        (test_busy),
        .test_done        (test_done),
        .fault_map        (fault_map),
        .STW_test_load_en (STW_test_load_en),
        .STW_mult_op1     (STW_mult_op1),
        .STW_mult_op2     (STW_mult_op2),
        .STW_add_op       (STW_add_op),
        .STW_expected     (STW_expected),
        .STW_start        (STW_start),
        .STW_complete     (STW_complete),
        .STW_result_out   (STW_result_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        busy, done, load, start;
        logic [15:0] op1, op2, add, exp;
        logic [3:0]  fm;
    } expRec_t;

    expRec_t     expQ[$];
    expRec_t     cmpRec;
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          doneCyc    = -1;
    int          acceptCyc  = 0;

    // Model of what the outputs must currently hold.
    logic [15:0] mOp1 = '0, mOp2 = '0, mAdd = '0, mExp = '0;
    logic [3:0]  mFm  = '0;

    // PE behaviour per sweep: cycles low after start, per-vector pass mask, vector a PE hangs from.
    int          lat[NV][NPE];
    logic [3:0]  passMask[NV];
    int          hangFrom[NPE];

`ifdef STW_LFSR_VECTORS_EN
    logic [15:0] mLfsr = SEED;

    function automatic logic [15:0] lfsrNext(input logic [15:0] s);
        if (s[0]) return (s >> 1) ^ 16'hB400;
        return s >> 1;
    endfunction
`else
    logic [15:0] tblOp1[8] = '{16'd3, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h00FF, 16'hFFFE, 16'h8000, 16'h0001};
    logic [15:0] tblOp2[8] = '{16'd5, 16'hFFFF, 16'h0002, 16'h1234, 16'h0100, 16'h0003, 16'hFFFF, 16'h0001};
    logic [15:0] tblAdd[8] = '{16'd7, 16'h0000, 16'h0000, 16'h5678, 16'h0001, 16'hFFFC, 16'h0000, 16'hFFFF};
    logic [15:0] litExp[8] = '{16'd22, 16'd1, 16'hFFFE, 16'h5678, 16'hFF01, 16'hFFF6, 16'h8000, 16'h0000};
`endif

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [15:0] macExp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        int p;
        p = int'($signed(a)) * int'($signed(b)) + int'($signed(c));
        return p[15:0];
    endfunction

    function automatic expRec_t mk(input logic b, input logic d, input logic l, input logic s);
        expRec_t r;
        r.busy = b; r.done = d; r.load = l; r.start = s;
        r.op1 = mOp1; r.op2 = mOp2; r.add = mAdd; r.exp = mExp; r.fm = mFm;
        return r;
    endfunction

    // Complete lines k cycles after start (k=1 is the first wait cycle).
    function automatic logic [3:0] peComplete(input int v, input int k);
        logic [3:0] c;
        for (int i = 0; i < NPE; i++) c[i] = (v < hangFrom[i]) && (k > lat[v][i]);
        return c;
    endfunction

    function automatic logic randReq();
        return ($urandom_range(0, 3) == 0);
    endfunction

    function automatic void loadVector(input int v);
`ifdef STW_LFSR_VECTORS_EN
        mOp1 = mLfsr;
        mOp2 = {mLfsr[7:0], mLfsr[15:8]};
        mAdd = ~mLfsr;
`else
        mOp1 = tblOp1[v % 8];
        mOp2 = tblOp2[v % 8];
        mAdd = tblAdd[v % 8];
`endif
        mExp = macExp(mOp1, mOp2, mAdd);
    endfunction

    function automatic void resetModel();
        mOp1 = '0; mOp2 = '0; mAdd = '0; mExp = '0; mFm = '0;
`ifdef STW_LFSR_VECTORS_EN
        mLfsr = SEED;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Single compare process: every scheduled cycle is checked against the model.
    always @(negedge clk) begin
        if (test_done === 1'b1) doneCyc = cyc;
        if (expQ.size() > 0) begin
            cmpRec = expQ.pop_front();
            checkOutput("busy",     32'(test_busy),        32'(cmpRec.busy));
            checkOutput("done",     32'(test_done),        32'(cmpRec.done));
            checkOutput("loadEn",   32'(STW_test_load_en), 32'(cmpRec.load));
            checkOutput("start",    32'(STW_start),        32'(cmpRec.start));
            checkOutput("op1",      32'(STW_mult_op1),     32'(cmpRec.op1));
            checkOutput("op2",      32'(STW_mult_op2),     32'(cmpRec.op2));
            checkOutput("add",      32'(STW_add_op),       32'(cmpRec.add));
            checkOutput("expected", 32'(STW_expected),     32'(cmpRec.exp));
            checkOutput("faultMap", 32'(fault_map),        32'(cmpRec.fm));
        end
    end

    task automatic applyStimulus(input expRec_t r, input logic [3:0] c, input logic [3:0] rs, input logic rq);
        @(posedge clk);
        #1;
        STW_complete   = c;
        STW_result_out = rs;
        test_req       = rq;
        expQ.push_back(r);
    endtask

    task automatic checkZero(input string pfx);
        checkOutput({pfx, "Busy"},  32'(test_busy),        32'd0);
        checkOutput({pfx, "Done"},  32'(test_done),        32'd0);
        checkOutput({pfx, "Load"},  32'(STW_test_load_en), 32'd0);
        checkOutput({pfx, "Start"}, 32'(STW_start),        32'd0);
        checkOutput({pfx, "Op1"},   32'(STW_mult_op1),     32'd0);
        checkOutput({pfx, "Op2"},   32'(STW_mult_op2),     32'd0);
        checkOutput({pfx, "Add"},   32'(STW_add_op),       32'd0);
        checkOutput({pfx, "Exp"},   32'(STW_expected),     32'd0);
        checkOutput({pfx, "Fault"}, 32'(fault_map),        32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(mk(0, 0, 0, 0), 4'hF, 4'($urandom), 1'b0);
    endtask

    task automatic doAbort();
        @(posedge clk);
        #1;
        STW_result_out = 4'($urandom);
        #1;
        rst = 1'b0;
        #1;
        checkZero("abort");
        @(posedge clk);
        #1;
        rst      = 1'b1;
        test_req = 1'b0;
        resetModel();
        expQ.push_back(mk(0, 0, 0, 0));
    endtask

    task automatic setAll(input int l);
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < NPE; i++) lat[v][i] = l;
            passMask[v] = 4'hF;
        end
        for (int i = 0; i < NPE; i++) hangFrom[i] = NV;
    endtask

    task automatic randomConfig();
        int r;
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < NPE; i++) begin
                r = $urandom_range(0, 19);
                if (r == 0)      lat[v][i] = TO - 1;
                else if (r == 1) lat[v][i] = TO;
                else if (r == 2) lat[v][i] = $urandom_range(6, 20);
                else             lat[v][i] = $urandom_range(0, 5);
            end
            passMask[v] = 4'hF;
            if ($urandom_range(0, 5) == 0) passMask[v][$urandom_range(0, 3)] = 1'b0;
        end
        for (int i = 0; i < NPE; i++)
            hangFrom[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NV - 1)) : NV;
    endtask

    // One sweep: the schedule length of each vector follows from when every PE reports complete.
    task automatic runSweep(input logic reqAtDone, input int abortVec);
        int         n;
        int         expLat;
        logic [3:0] c;
        doneCyc = -1;
        expLat  = 0;
        applyStimulus(mk(0, 0, 0, 0), 4'hF, 4'($urandom), 1'b1);
        acceptCyc = cyc + 1;
        mFm = '0;
        for (int v = 0; v < NV; v++) begin
            loadVector(v);
            applyStimulus(mk(1, 0, 1, 0), peComplete(v, 1000), 4'($urandom), randReq());
`ifndef STW_LFSR_VECTORS_EN
            #1 checkOutput("tableExpected", 32'(STW_expected), 32'(litExp[v % 8]));
`endif
            applyStimulus(mk(1, 0, 0, 1), peComplete(v, 1000), 4'($urandom), randReq());
            n = TO;
            for (int k = 2; k <= TO; k++) begin
                c = peComplete(v, k);
                if (&c) begin
                    n = k;
                    break;
                end
            end
            for (int k = 1; k <= n; k++) begin
                if (v == abortVec && k == 2) begin
                    doAbort();
                    return;
                end
                applyStimulus(mk(1, 0, 0, 0), peComplete(v, k), 4'($urandom), randReq());
            end
            c = peComplete(v, n + 1);
            applyStimulus(mk(1, 0, 0, 0), c, passMask[v], randReq());
            mFm = mFm | ~(c & passMask[v]);
            applyStimulus(mk(1, 0, 0, 0), c, 4'($urandom), randReq());
            expLat += n + 4;
`ifdef STW_LFSR_VECTORS_EN
            mLfsr = lfsrNext(mLfsr);
`endif
        end
        applyStimulus(mk(1, 1, 0, 0), 4'hF, 4'($urandom), reqAtDone);
        @(negedge clk);
        #1;
        checkOutput("sweepLatency", 32'(doneCyc - acceptCyc), 32'(expLat));
    endtask

    initial begin
        rst            = 1'b0;
        test_req       = 1'b0;
        STW_complete   = 4'hF;
        STW_result_out = 4'h0;
        setAll(0);
        #1;
        checkZero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        expQ.push_back(mk(0, 0, 0, 0));
        idle(2);

        // All pass, complete low for two wait cycles: seven cycles per vector.
        setAll(2);
        runSweep(1'b0, -1);
        checkOutput("allPassFault", 32'(fault_map), 32'h0);
        checkOutput("allPassDoneAt56", 32'(doneCyc - acceptCyc), 32'd56);
        idle(2);

        // PE 2 fails vector 5 only.
        setAll(1);
        passMask[5] = 4'b1011;
        runSweep(1'b0, -1);
        checkOutput("pe2Vec5Fault", 32'(fault_map), 32'h4);
        idle(2);

        // PE 1 never completes; request held through DONE chains a second sweep.
        setAll(1);
        hangFrom[1] = 0;
        runSweep(1'b1, -1);
        checkOutput("pe1HangFault", 32'(fault_map), 32'h2);
        checkOutput("pe1HangLatency", 32'(doneCyc - acceptCyc), 32'd544);
        setAll(0);
        runSweep(1'b0, -1);
        checkOutput("chainedFault", 32'(fault_map), 32'h0);
        idle(2);

        // Reset during the wait of vector 3, then a fresh sweep from vector 0.
        setAll(2);
        runSweep(1'b0, 3);
        idle(3);
        setAll(2);
        runSweep(1'b0, -1);
        idle(2);

        for (int s = 0; s < 8; s++) begin
            logic chain;
            randomConfig();
            chain = 1'($urandom_range(0, 1));
            runSweep(chain, -1);
            if (!chain) idle($urandom_range(1, 3));
        end
        idle(3);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
